// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter sharing one 8-bit parallel-load shift register between two byte requesters.
// Drives load/data, marks the serial bit window and frame end, then holds off for a configurable gap.
module shift_reg_arbiter #(
  parameter int BIT_COUNT = 8,
  parameter int GAP       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       sr_load,
  output logic [7:0] sr_data,
  output logic       bit_valid,
  output logic       frame_done,
  output logic       busy,
  output logic       grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [7:0] LAST_BIT = 8'(BIT_COUNT - 1);
  localparam logic [7:0] LAST_GAP = 8'(GAP - 1);
  localparam bit         HAS_GAP  = (GAP > 0);

  logic [1:0] state;
  logic [7:0] bit_cnt;
  logic [7:0] gap_cnt;
  logic       ptr;
  logic       any_req;
  logic       winner;

  // ptr holds the last winner; on a tie the other requester goes next.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = ~ptr;
    end else begin
      winner = req1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 8'd0;
      gap_cnt    <= 8'd0;
      ptr        <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      sr_load    <= 1'b0;
      sr_data    <= 8'h00;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      sr_load <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state    <= S_LOAD;
            grant_id <= winner;
            sr_data  <= winner ? data1 : data0;
            sr_load  <= 1'b1;
            ack0     <= ~winner;
            ack1     <= winner;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          ptr        <= grant_id;
          bit_cnt    <= 8'd0;
          state      <= S_SHIFT;
          bit_valid  <= 1'b1;
          frame_done <= (LAST_BIT == 8'd0);
        end
        S_SHIFT: begin
          // frame_done is registered, so it is raised one count ahead of the last bit.
          if (bit_cnt == LAST_BIT) begin
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            gap_cnt    <= 8'd0;
            if (HAS_GAP) begin
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt    <= bit_cnt + 8'd1;
            frame_done <= ((bit_cnt + 8'd1) == LAST_BIT);
          end
        end
        S_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1));
  a_ack_load:   assert property (@(posedge clk) disable iff (rst) (ack0 || ack1) == sr_load);
  a_done_bit:   assert property (@(posedge clk) disable iff (rst) frame_done |-> bit_valid);

endmodule
